sync_share_scheduler: RTL and testbench
=======================================

Name: sync_share_scheduler

Overview:
Write-domain controller that shares one multi-bit syncronizer between N_REQ requesters.
It arbitrates requests round-robin and presents {toggle, idx, data} as the syncronizer's w_value_i input, using a bundled-data protocol.
Data/idx settle first; the toggle flips afterwards; the word is then held stable long enough for the read domain to sample it without multi-bit metastability corruption.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 4, payload width per requester
SETTLE_CYCLES, 2, cycles between data/idx load and toggle flip (>=1)
HOLD_CYCLES, 6, cycles the word is held after toggle flip (>=1; sized from clock ratio, >= 3 read-clock periods)
IDX_W, max(1,$clog2(N_REQ)), localparam, requester index width

Ports:
w_clk_i  input  1  write-domain clock
w_rstn_i  input  1  asynchronous active-low reset
enable_i  input  1  1 = new grants allowed; 0 = finish in-flight transfer only
req_i  input  N_REQ  per-requester request, level; held until granted
data_i  input  N_REQ*DATA_W  payloads, requester k at [k*DATA_W +: DATA_W]
gnt_o  output  N_REQ  one-hot, one-cycle grant pulse (registered)
sync_value_o  output  1+IDX_W+DATA_W  {toggle, idx, data} to syncronizer w_value_i
busy_o  output  1  registered, 1 when state != IDLE
xfer_cnt_o  output  16  completed-transfer count, wraps at 0xFFFF->0

Behaviour:
- Reset (async, w_rstn_i low): state=IDLE, gnt_o=0, sync_value_o=0, busy_o=0, xfer_cnt_o=0, cnt=0, rr pointer=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If enable_i=1 and |req_i, choose the winner as the first set req bit searching from ptr+1 mod N_REQ upward.
  - At that edge: latch data_i slice and winner index into sync_value_o (toggle unchanged); set gnt_o one-hot to the winner; ptr<=winner; cnt<=SETTLE_CYCLES-1; state->SETTLE.
  - Otherwise gnt_o=0 and sync_value_o holds.
- SETTLE: if cnt!=0, cnt--. If cnt==0: toggle inverts, cnt<=HOLD_CYCLES-1, state->HOLD.
- HOLD: if cnt!=0, cnt--. If cnt==0: state->IDLE, xfer_cnt_o++.
- gnt_o is high for exactly the single cycle after the accept edge; it is 0 at all other times.
- Timing from accept edge e0:
  - toggle flips at edge e0+SETTLE_CYCLES.
  - busy_o falls at e0+SETTLE_CYCLES+HOLD_CYCLES.
  - Earliest next accept is e0+SETTLE_CYCLES+HOLD_CYCLES+1.
- Invariant: data/idx change only at an accept edge, and toggle changes only at the SETTLE->HOLD edge. They never change on the same edge, and sync_value_o is otherwise constant.
- The receiver detects a new word by a toggle change. idx and data are valid whenever toggle differs from its previous value.
- req_i while busy: ignored, not queued. A requester that drops req before grant receives no grant.
- enable_i=0 mid-transfer: the transfer completes normally; the FSM then stays in IDLE.
- Simultaneous requests: exactly one grant; ptr rotation guarantees each active requester is served within N_REQ transfers.
- Reset mid-transfer: everything returns to reset values immediately. The toggle returns to 0, which the read side sees as a possible single spurious edge; this is documented and acceptable because both domains reset together.

Decomposition:
- Package sync_sched_pkg: state enum (IDLE/SETTLE/HOLD), function for clog2-min-1 index width, and a packed struct type for the {toggle, idx, data} word.
- Sub-module rr_arbiter (N_REQ): combinational req + ptr -> one-hot winner plus index.

Test Plan:
- Single request (N_REQ=4, DATA_W=4, SETTLE=2, HOLD=6): req_i=0010, data1=0xA at edge e0 -> gnt_o=0010 for one cycle; sync_value_o={0,1,0xA} after e0, {1,1,0xA} after e2; busy_o low after e8; xfer_cnt_o=1.
- All requesting continuously (req_i=1111, data k=k+3) -> grants in order 0,1,2,3,0; accepts spaced exactly 9 cycles; toggle alternates 1,0,1,0,1.
- Request during HOLD: req_i=0100 raised at e4 of a transfer -> no gnt until the accept at e9; payload is latched at e9.
- enable_i dropped at e1 with req_i=1111 -> current transfer completes (toggle flips at e2, IDLE at e8); no further gnt while enable_i=0; the next grant comes one edge after enable_i returns to 1.
- Async reset asserted at e3 (in HOLD) -> outputs, ptr and counters clear immediately; after release, req_i=1000 -> first grant goes to requester 3 with toggle flipping 0->1.
- Pair with the syncronizer metastability model for 10k random transfers -> the read side decodes every toggle change with idx/data matching the sent word, with zero mismatches.

Source files
------------

// File: rtl/sync_sched_pkg.sv
// sync_sched_pkg: shared types and helpers for the shared-synchroniser scheduler.
//   state_e   : scheduler FSM states (IDLE/SETTLE/HOLD)
//   idx_width : index width for n items, never below 1 bit
package sync_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1.
//   req_i   : request vector
//   ptr_i   : index of the last winner
//   gnt_o   : one-hot winner (zero when nothing requested)
//   idx_o   : winner index
//   valid_o : any request present
module rr_arbiter import sync_sched_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] k;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      k       = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         k = IDX_W'((int'(ptr_i) + i) % N_REQ);
         if (!valid_o && req_i[k]) begin
            valid_o  = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end

endmodule

// File: rtl/sync_share_scheduler.sv
// sync_share_scheduler: shares one bundled-data synchroniser between N_REQ requesters.
//   w_clk_i      : write-domain clock
//   w_rstn_i     : asynchronous active-low reset
//   enable_i     : allow new grants (an in-flight transfer always completes)
//   req_i        : level requests, one per requester
//   data_i       : payloads, requester k at [k*DATA_W +: DATA_W]
//   gnt_o        : registered one-cycle one-hot grant pulse
//   sync_value_o : {toggle, idx, data} for the synchroniser input
//   busy_o       : registered, high while a transfer is in flight
//   xfer_cnt_o   : completed-transfer count, wraps
module sync_share_scheduler import sync_sched_pkg::*; #(
   parameter  int N_REQ         = 4,
   parameter  int DATA_W        = 4,
   parameter  int SETTLE_CYCLES = 2,
   parameter  int HOLD_CYCLES   = 6,
   localparam int IDX_W         = idx_width(N_REQ)
) (
   input  logic                      w_clk_i,
   input  logic                      w_rstn_i,
   input  logic                      enable_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*DATA_W-1:0]   data_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [IDX_W+DATA_W:0]     sync_value_o,
   output logic                      busy_o,
   output logic [15:0]               xfer_cnt_o
);

   localparam int CNT_W = idx_width(SETTLE_CYCLES > HOLD_CYCLES ? SETTLE_CYCLES : HOLD_CYCLES);

   typedef struct packed {
      logic              tog;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } word_t;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   word_t            word_q, word_d;
   logic             busy_q;
   logic [15:0]      xfer_q, xfer_d;

   logic [N_REQ-1:0] win_gnt;
   logic [IDX_W-1:0] win_idx;
   logic             win_valid;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (win_gnt),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   // idx/data move only on accept, toggle only on SETTLE->HOLD, so the
   // bundled word never changes more than one field class per edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      word_d  = word_q;
      xfer_d  = xfer_q;
      case (state_q)
         IDLE: if (enable_i && win_valid) begin
            word_d.idx  = win_idx;
            word_d.data = data_i[int'(win_idx)*DATA_W +: DATA_W];
            gnt_d       = win_gnt;
            ptr_d       = win_idx;
            cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
            state_d     = SETTLE;
         end
         SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else begin
            word_d.tog = ~word_q.tog;
            cnt_d      = CNT_W'(HOLD_CYCLES - 1);
            state_d    = HOLD;
         end
         HOLD: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else begin
            xfer_d  = xfer_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge w_clk_i or negedge w_rstn_i) begin
      if (!w_rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         gnt_q   <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         xfer_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         word_q  <= word_d;
         busy_q  <= (state_d != IDLE);
         xfer_q  <= xfer_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign sync_value_o = word_q;
   assign busy_o       = busy_q;
   assign xfer_cnt_o   = xfer_q;

endmodule

// File: tb/tb_sync_share_scheduler.sv
// tb_sync_share_scheduler: directed and random checks against a timing-based model plus a read-side decoder.
module tb_sync_share_scheduler;

   localparam int N = 4;
   localparam int S = 2;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] data = '0;
   logic [3:0]  gnt_o;
   logic [6:0]  sync_value_o;
   logic        busy_o;
   logic [15:0] xfer_cnt_o;

   int checks = 0;
   int errs = 0;

   sync_share_scheduler #(.N_REQ(N), .DATA_W(4), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
      .w_clk_i      (clk),
      .w_rstn_i     (rst_n),
      .enable_i     (en),
      .req_i        (req),
      .data_i       (data),
      .gnt_o        (gnt_o),
      .sync_value_o (sync_value_o),
      .busy_o       (busy_o),
      .xfer_cnt_o   (xfer_cnt_o)
   );

   always #5 clk = ~clk;
   initial begin
      #3;
      forever #7 rclk = ~rclk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: everything is derived from the edge number of the last accept.
   int          n = 0;
   int          acc = -100;
   int          m_ptr = N - 1;
   logic        m_tog = 1'b0;
   logic [1:0]  m_idx = '0;
   logic [3:0]  m_data = '0;
   logic [15:0] m_xfer = '0;
   logic [5:0]  sent[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc = -100; m_ptr = N - 1; m_tog = 1'b0; m_idx = '0; m_data = '0; m_xfer = '0;
         sent.delete();
      end else begin
         n++;
         if (n == acc + S) begin
            m_tog = ~m_tog;
            sent.push_back({m_idx, m_data});
         end
         if (n == acc + S + H) m_xfer = m_xfer + 16'd1;
         if (n > acc + S + H && en && req != 0) begin
            int w;
            w = -1;
            for (int i = 1; i <= N; i++)
               if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            acc = n; m_ptr = w; m_idx = 2'(w); m_data = data[w*4 +: 4];
         end
      end
   end

   always @(negedge clk) begin
      chk("gnt", gnt_o, (acc == n) ? (32'd1 << m_ptr) : 32'd0);
      chk("sync_value", sync_value_o, {m_tog, m_idx, m_data});
      chk("busy", busy_o, (n >= acc && n < acc + S + H) ? 1 : 0);
      chk("xfer_cnt", xfer_cnt_o, m_xfer);
   end

   // Read side: two-flop synchroniser; bits that changed within 2ns of the
   // sampling edge resolve randomly.
   logic [6:0] cur_w = '0, old_w = '0, s1 = '0, s2 = '0;
   logic       ptog = 1'b0;
   time        t_chg = 0;

   always @(sync_value_o) begin
      old_w = cur_w; cur_w = sync_value_o; t_chg = $time;
   end

   always @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         s1 = '0; s2 = '0; ptog = 1'b0;
      end else begin
         s2 = s1;
         s1 = ($time - t_chg < 2) ? ((cur_w & ~(cur_w ^ old_w)) | (7'($urandom) & (cur_w ^ old_w))) : cur_w;
         if (s2[6] != ptog) begin
            ptog = s2[6];
            if (sent.size() == 0) chk("rx_unexpected", {26'd0, s2[5:0]}, 32'hFFFF_FFFF);
            else chk("rx_word", s2[5:0], sent.pop_front());
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_reset();
      en = 1'b0; req = '0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   int gi[$], gc[$];
   int exp_o[5] = '{0, 1, 2, 3, 0};
   logic [3:0] g;

   initial begin
      tick(2);
      #1 rst_n = 1'b1;
      // single request
      @(negedge clk);
      en = 1'b1; req = 4'b0010; data = 16'h00A0;
      tick(1);
      chk("t1_gnt", gnt_o, 4'b0010);
      chk("t1_word0", sync_value_o, 7'h1A);
      req = '0;
      tick(1);
      chk("t1_gnt_pulse", gnt_o, 0);
      tick(1);
      chk("t1_word1", sync_value_o, 7'h5A);
      tick(5);
      chk("t1_busy_e7", busy_o, 1);
      tick(1);
      chk("t1_busy_e8", busy_o, 0);
      chk("t1_xfer", xfer_cnt_o, 1);
      // all requesting
      do_reset();
      en = 1'b1; req = 4'b1111; data = 16'h6543;
      for (int c = 0; c < 45; c++) begin
         tick(1);
         if (gnt_o != 0) begin gi.push_back($clog2(gnt_o)); gc.push_back(c); end
      end
      chk("rr_count", gi.size(), 5);
      for (int i = 0; i < gi.size() && i < 5; i++) begin
         chk("rr_order", gi[i], exp_o[i]);
         if (i > 0) chk("rr_spacing", gc[i] - gc[i-1], 9);
      end
      // request raised during HOLD
      do_reset();
      en = 1'b1; req = 4'b0001; data = 16'h0C00;
      tick(1);
      req = '0;
      tick(4);
      req = 4'b0100;
      for (int i = 5; i < 9; i++) begin tick(1); chk("t3_no_gnt", gnt_o, 0); end
      tick(1);
      chk("t3_gnt", gnt_o, 4'b0100);
      chk("t3_word", sync_value_o, 7'h6C);
      req = '0;
      // enable dropped mid-transfer
      do_reset();
      en = 1'b1; req = 4'b1111;
      tick(1);
      chk("t4_gnt", gnt_o, 4'b0001);
      en = 1'b0; req = 4'b1110;
      tick(7);
      chk("t4_busy_e7", busy_o, 1);
      for (int i = 0; i < 6; i++) begin tick(1); chk("t4_idle_gnt", gnt_o, 0); end
      chk("t4_busy_idle", busy_o, 0);
      en = 1'b1;
      tick(1);
      chk("t4_regrant", gnt_o, 4'b0010);
      // async reset mid-transfer
      do_reset();
      en = 1'b1; req = 4'b1111;
      tick(1);
      req = '0;
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_word", sync_value_o, 0);
      chk("t5_rst_busy", busy_o, 0);
      chk("t5_rst_gnt", gnt_o, 0);
      chk("t5_rst_xfer", xfer_cnt_o, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      req = 4'b1000; data = 16'h5000;
      tick(1);
      chk("t5_gnt", gnt_o, 4'b1000);
      chk("t5_word0", sync_value_o, 7'h35);
      req = '0;
      tick(2);
      chk("t5_word1", sync_value_o, 7'h75);
      // random traffic
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         g = gnt_o;
         for (int k = 0; k < N; k++)
            req[k] = g[k] ? 1'b0 : req[k] ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 4) == 0);
         en = ($urandom_range(0, 9) != 0);
         data = 16'($urandom);
         if ($urandom_range(0, 2999) == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      req = '0;
      for (int i = 0; i < 200 && (sent.size() != 0 || busy_o); i++) tick(1);
      chk("rx_drain", sent.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
